write_back_buffer: RTL
======================

// Module: write_back_buffer
// PURPOSE
//  Sits between the cache controller's memory port and main memory. Absorbs dirty-line write-backs into a
//  small FIFO so evictions don't stall the cache, and drains them to memory when the controller is idle.
//  Services read misses, forwarding buffered data on a line-address match. Line = 64 bits; line addr = addr[31:3].
// PARAMETERS
//  DEPTH   4   buffered write-back entries (power of 2, >=2)
//  ADDR_W  32  byte address width
//  DATA_W  64  line data width
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active-high
//  up_req_valid  in   1       cache request valid; held until up_res_ready
//  up_req_rw     in   1       1=write-back line, 0=line read
//  up_req_addr   in   ADDR_W  byte address (bits [2:0] ignored)
//  up_req_data   in   DATA_W  write-back line data
//  up_res_ready  out  1       one-cycle completion pulse
//  up_res_data   out  DATA_W  read data, valid while up_res_ready=1
//  dn_req_valid  out  1       memory request valid; held until dn_res_ready
//  dn_req_rw     out  1       1=write, 0=read
//  dn_req_addr   out  ADDR_W  line-aligned byte address ([2:0]=0)
//  dn_req_data   out  DATA_W  write data
//  dn_res_ready  in   1       memory done; level, may stay high after valid drops
//  dn_res_data   in   DATA_W  memory read data, sampled when dn_res_ready=1
//  occupancy     out  $clog2(DEPTH)+1  valid entries; full = (occupancy==DEPTH)
// BEHAVIOUR
//  Reset: all entries invalid, occupancy=0, FSM=IDLE, every output 0, armed=1. Mid-operation reset
//   drops dn_req_valid immediately (async); buffered data is lost by design.
//  Upstream acceptance is edge-based: request taken only in IDLE with up_req_valid=1 and armed=1;
//   taking it clears armed; armed re-sets on any cycle with up_req_valid=0.
//  FSM: IDLE, UP_RSP, RD_MEM, DRAIN, DN_WAIT. IDLE priority: upstream request > drain.
//  Write, line matches valid entry: coalesce (overwrite data in place; order/occupancy unchanged) -> UP_RSP.
//  Write, no match, not full: enqueue at tail -> UP_RSP. Full + no match: stall in IDLE (not taken,
//   armed kept) and start DRAIN; retry after the pop.
//  Read, match: up_res_data = matched entry data (coalescing keeps one entry per line) -> UP_RSP.
//  Read, no match: issue dn read -> RD_MEM; on dn_res_ready capture dn_res_data, drop dn_req_valid -> UP_RSP.
//  UP_RSP: up_res_ready=1 for exactly one cycle -> DN_WAIT if a dn request just finished, else IDLE.
//   Write/read-hit latency: acceptance edge +1 cycle.
//  IDLE, no request, occupancy>0: issue head as dn write -> DRAIN; on dn_res_ready pop head, drop dn_req_valid -> DN_WAIT.
//  DN_WAIT: hold until dn_res_ready=0, then IDLE. No new dn request while dn_res_ready=1.
//  dn_req_* stable whenever dn_req_valid=1; dn_req_valid=0 in IDLE, UP_RSP, DN_WAIT.
//  Head/tail pointers wrap mod DEPTH; occupancy never exceeds DEPTH or underflows.
//  Enqueue and pop never occur in the same cycle (different states).
// CONFIGURATION
//  WBB_STATS_EN defined: extra outputs rd_hit_cnt[15:0], coalesce_cnt[15:0]. Each increments once
//   per accepted read hit / write coalesce and saturates at 16'hFFFF. Both clear on rst.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset mid-DRAIN -> dn_req_valid=0 same cycle, occupancy=0, up_res_ready=0.
//  2 Write 0xE4 data 0xABCDEFAB_00000000 -> up_res_ready 1 cycle later, occupancy=1.
//    Then it drains: dn write addr 0xE0, then occupancy=0.
//  3 Write 0x1E0 =A, write 0x1E0 =B back-to-back (valid dropped between) -> occupancy=1.
//    Read 0x1E4 -> up_res_data=B with no dn read issued; coalesce_cnt=1 with WBB_STATS_EN.
//  4 Fill 4 writes 0x000/0x008/0x010/0x018, memory held not-ready; 5th write 0x020 -> no pulse until
//    head 0x000 drained, then accepted, occupancy=4.
//  5 Read miss 0x2E0, memory returns 0x1122334455667788 after 2 cycles -> up_res_ready pulse with that data;
//    next dn request not issued until dn_res_ready=0.
//  6 Drain in progress + new write arriving -> write waits for DRAIN and DN_WAIT; FIFO order preserved
//    on dn (addresses in enqueue order).

Source files
------------

// File: rtl/write_back_buffer.sv
// write_back_buffer
//   Write-back buffer between a cache controller's memory port and main memory.
//   Dirty-line write-backs are absorbed into a small FIFO (coalescing writes to a
//   line that is already buffered) and drained to memory whenever the upstream
//   side is idle. Line reads are answered from the buffer on a line-address hit,
//   otherwise forwarded to memory.
//
//   Ports
//     clk, rst                 clock (rising edge), asynchronous active-high reset
//     up_req_valid/rw/addr/data  upstream request (rw=1 write-back, 0 line read)
//     up_res_ready/data        one-cycle completion pulse and read data
//     dn_req_valid/rw/addr/data  memory request, held until dn_res_ready
//     dn_res_ready/data        memory completion (level) and read data
//     occupancy                number of buffered lines
//
//   Configuration macro WBB_STATS_EN adds saturating counters rd_hit_cnt and
//   coalesce_cnt as extra outputs; without it those ports do not exist.
module write_back_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up_req_valid,
    input  logic                   up_req_rw,
    input  logic [ADDR_W-1:0]      up_req_addr,
    input  logic [DATA_W-1:0]      up_req_data,
    output logic                   up_res_ready,
    output logic [DATA_W-1:0]      up_res_data,
    output logic                   dn_req_valid,
    output logic                   dn_req_rw,
    output logic [ADDR_W-1:0]      dn_req_addr,
    output logic [DATA_W-1:0]      dn_req_data,
    input  logic                   dn_res_ready,
    input  logic [DATA_W-1:0]      dn_res_data,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef WBB_STATS_EN
    ,
    output logic [15:0]            rd_hit_cnt,
    output logic [15:0]            coalesce_cnt
`endif
);

    // state    | meaning
    // IDLE     | accepting upstream requests, else draining the head entry
    // UP_RSP   | one-cycle up_res_ready pulse
    // RD_MEM   | read miss outstanding on the memory port
    // DRAIN    | head entry being written to memory
    // DN_WAIT  | waiting for dn_res_ready to fall before any new memory request
    typedef enum logic [2:0] {S_IDLE, S_UP_RSP, S_RD_MEM, S_DRAIN, S_DN_WAIT} state_t;

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int LINE_W = ADDR_W - 3;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    state_t              state_q, state_d;
    logic                armed_q, armed_d;
    logic                rd_miss_q, rd_miss_d;
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                vld_q  [DEPTH];
    logic                vld_d  [DEPTH];
    logic [LINE_W-1:0]   line_q [DEPTH];
    logic [LINE_W-1:0]   line_d [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DATA_W-1:0]   data_d [DEPTH];
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                dn_rw_q, dn_rw_d;
    logic [LINE_W-1:0]   dn_line_q, dn_line_d;
    logic [DATA_W-1:0]   dn_data_q, dn_data_d;

    logic                hit;
    logic [PTR_W-1:0]    hit_idx;
    logic                full;
    logic [LINE_W-1:0]   req_line;
    logic                addr_lsb_unused;

    assign req_line        = up_req_addr[ADDR_W-1:3];
    assign addr_lsb_unused = ^up_req_addr[2:0];
    assign full            = (occ_q == FULL_OCC);

    // Coalescing guarantees at most one valid entry per line.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && line_q[i] == req_line) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        rd_miss_d  = rd_miss_q;
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        vld_d      = vld_q;
        line_d     = line_q;
        data_d     = data_q;
        res_data_d = res_data_q;
        dn_rw_d    = dn_rw_q;
        dn_line_d  = dn_line_q;
        dn_data_d  = dn_data_q;

        // Acceptance is edge-based: a held request is taken only once.
        if (!up_req_valid) armed_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (up_req_valid && armed_q) begin
                    if (up_req_rw) begin
                        if (hit) begin
                            data_d[hit_idx] = up_req_data;
                            armed_d         = 1'b0;
                            state_d         = S_UP_RSP;
                        end else if (!full) begin
                            vld_d[tail_q]  = 1'b1;
                            line_d[tail_q] = req_line;
                            data_d[tail_q] = up_req_data;
                            tail_d         = tail_q + 1'b1;
                            occ_d          = occ_q + 1'b1;
                            armed_d        = 1'b0;
                            state_d        = S_UP_RSP;
                        end else if (!dn_res_ready) begin
                            // Full with no match: request stays pending, make room.
                            dn_rw_d   = 1'b1;
                            dn_line_d = line_q[head_q];
                            dn_data_d = data_q[head_q];
                            state_d   = S_DRAIN;
                        end
                    end else if (hit) begin
                        res_data_d = data_q[hit_idx];
                        armed_d    = 1'b0;
                        state_d    = S_UP_RSP;
                    end else if (!dn_res_ready) begin
                        dn_rw_d   = 1'b0;
                        dn_line_d = req_line;
                        dn_data_d = '0;
                        armed_d   = 1'b0;
                        state_d   = S_RD_MEM;
                    end
                end else if (occ_q != '0 && !dn_res_ready) begin
                    dn_rw_d   = 1'b1;
                    dn_line_d = line_q[head_q];
                    dn_data_d = data_q[head_q];
                    state_d   = S_DRAIN;
                end
            end
            S_RD_MEM: begin
                if (dn_res_ready) begin
                    res_data_d = dn_res_data;
                    rd_miss_d  = 1'b1;
                    state_d    = S_UP_RSP;
                end
            end
            S_UP_RSP: begin
                rd_miss_d = 1'b0;
                state_d   = rd_miss_q ? S_DN_WAIT : S_IDLE;
            end
            S_DRAIN: begin
                if (dn_res_ready) begin
                    vld_d[head_q] = 1'b0;
                    head_d        = head_q + 1'b1;
                    occ_d         = occ_q - 1'b1;
                    state_d       = S_DN_WAIT;
                end
            end
            S_DN_WAIT: begin
                if (!dn_res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b1;
            rd_miss_q  <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            res_data_q <= '0;
            dn_rw_q    <= 1'b0;
            dn_line_q  <= '0;
            dn_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i]  <= 1'b0;
                line_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            rd_miss_q  <= rd_miss_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            res_data_q <= res_data_d;
            dn_rw_q    <= dn_rw_d;
            dn_line_q  <= dn_line_d;
            dn_data_q  <= dn_data_d;
            vld_q      <= vld_d;
            line_q     <= line_d;
            data_q     <= data_d;
        end
    end

    assign up_res_ready = (state_q == S_UP_RSP);
    assign up_res_data  = res_data_q;
    assign dn_req_valid = (state_q == S_RD_MEM) || (state_q == S_DRAIN);
    assign dn_req_rw    = dn_rw_q;
    assign dn_req_addr  = {dn_line_q, 3'b000};
    assign dn_req_data  = dn_data_q;
    assign occupancy    = occ_q;

`ifdef WBB_STATS_EN
    logic [15:0] rd_hit_cnt_q, rd_hit_cnt_d;
    logic [15:0] coalesce_cnt_q, coalesce_cnt_d;
    logic        hit_taken;

    always_comb begin
        rd_hit_cnt_d   = rd_hit_cnt_q;
        coalesce_cnt_d = coalesce_cnt_q;
        hit_taken      = (state_q == S_IDLE) && up_req_valid && armed_q && hit;
        if (hit_taken && !up_req_rw && rd_hit_cnt_q != 16'hFFFF)
            rd_hit_cnt_d = rd_hit_cnt_q + 16'd1;
        if (hit_taken && up_req_rw && coalesce_cnt_q != 16'hFFFF)
            coalesce_cnt_d = coalesce_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_hit_cnt_q   <= '0;
            coalesce_cnt_q <= '0;
        end else begin
            rd_hit_cnt_q   <= rd_hit_cnt_d;
            coalesce_cnt_q <= coalesce_cnt_d;
        end
    end

    assign rd_hit_cnt   = rd_hit_cnt_q;
    assign coalesce_cnt = coalesce_cnt_q;
`endif

endmodule
